// File: rtl/demux_16bit_1x8_buf.sv
// Registered 1-to-8 word distributor: one holding buffer per channel with
// valid/ack flow control, target from explicit select or a round-robin pointer.
module demux_16bit_1x8_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic             auto_mode,
  output logic [2:0]       ptr,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ack
);

  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic [7:0]       valid_q;
  logic [7:0]       valid_d;
  logic [2:0]       ptr_q;
  logic [2:0]       ptr_d;
  logic [2:0]       tgt_s;
  logic             accept_s;

  // Target selection and handshake; a full target being acked can refill at once.
  always_comb begin
    if (auto_mode) begin
      tgt_s = ptr_q;
    end else begin
      tgt_s = sel;
    end
    in_ready = ~valid_q[tgt_s] | out_ack[tgt_s];
    accept_s = in_valid & in_ready;
  end

  // Next state: release acked channels first, then a same-cycle write re-sets valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~out_ack;
    ptr_d   = ptr_q;
    if (accept_s) begin
      data_d[tgt_s]  = in_data;
      valid_d[tgt_s] = 1'b1;
      if (auto_mode) begin
        ptr_d = ptr_q + 3'd1;
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; reset drops every buffered word immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= {WIDTH{1'b0}};
      end
      valid_q <= 8'h00;
      ptr_q   <= 3'd0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= data_d[k];
      end
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out1      = data_q[0];
  assign out2      = data_q[1];
  assign out3      = data_q[2];
  assign out4      = data_q[3];
  assign out5      = data_q[4];
  assign out6      = data_q[5];
  assign out7      = data_q[6];
  assign out8      = data_q[7];
  assign out_valid = valid_q;
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_demux_16bit_1x8_buf.sv
// Bench for demux_16bit_1x8_buf: directed test-plan steps plus random traffic,
// all checked against a channel-array reference model.
module tb_demux_16bit_1x8_buf;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic        auto_mode;
  logic [2:0]  ptr;
  logic [15:0] out1, out2, out3, out4, out5, out6, out7, out8;
  logic [7:0]  out_valid;
  logic [7:0]  out_ack;
  logic [15:0] dout [8];

  int checks;
  int failures;

  // reference model state
  logic [15:0] m_data  [8];
  bit          m_valid [8];
  int          m_ptr;

  demux_16bit_1x8_buf #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .auto_mode(auto_mode), .ptr(ptr),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out5(out5), .out6(out6), .out7(out7), .out8(out8),
    .out_valid(out_valid), .out_ack(out_ack)
  );

  assign dout[0] = out1;
  assign dout[1] = out2;
  assign dout[2] = out3;
  assign dout[3] = out4;
  assign dout[4] = out5;
  assign dout[5] = out6;
  assign dout[6] = out7;
  assign dout[7] = out8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_target();
    return auto_mode ? m_ptr : int'(sel);
  endfunction

  function automatic bit m_ready();
    int t;
    t = m_target();
    return !m_valid[t] || out_ack[t];
  endfunction

  function automatic logic [7:0] m_valid_vec();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_valid[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_data[k]  = 16'h0000;
      m_valid[k] = 1'b0;
    end
    m_ptr = 0;
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_out%0d", tag, k + 1), {16'h0000, dout[k]}, {16'h0000, m_data[k]});
    end
    chk({tag, "_valid"}, {24'h000000, out_valid}, {24'h000000, m_valid_vec()});
    chk({tag, "_ptr"}, {29'h0, ptr}, m_ptr);
  endtask

  // one clock: check in_ready, advance model at the edge, check registered state
  task automatic cycle(input string tag);
    bit acc;
    int t;
    #1;
    chk({tag, "_in_ready"}, {31'h0, in_ready}, {31'h0, m_ready()});
    t   = m_target();
    acc = in_valid && m_ready();
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (out_ack[k]) m_valid[k] = 1'b0;
    end
    if (acc) begin
      m_data[t]  = in_data;
      m_valid[t] = 1'b1;
      if (auto_mode) m_ptr = (m_ptr + 1) % 8;
    end
    #1;
    check_state(tag);
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit am,
                       input logic [2:0] s, input logic [7:0] ack);
    in_valid  = v;
    in_data   = d;
    auto_mode = am;
    sel       = s;
    out_ack   = ack;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_state("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b0, 16'h0000, 1'b0, 3'd0, 8'h00);
    do_reset();

    // explicit routing to channel 3
    drive(1'b1, 16'hA5A5, 1'b0, 3'd3, 8'h00);
    cycle("route_send");
    chk("route_out4", {16'h0, out4}, 32'h0000A5A5);
    chk("route_valid", {24'h0, out_valid}, 32'h00000008);
    drive(1'b0, 16'h0000, 1'b0, 3'd3, 8'h08);
    cycle("route_ack");
    chk("route_keep", {16'h0, out4}, 32'h0000A5A5);
    chk("route_valid0", {24'h0, out_valid}, 32'h00000000);

    // round-robin wrap with all consumers acking
    for (int i = 1; i <= 9; i++) begin
      chk($sformatf("rr_ptr_%0d", i), {29'h0, ptr}, (i - 1) % 8);
      drive(1'b1, 16'(i), 1'b1, 3'd0, 8'hFF);
      cycle($sformatf("rr_%0d", i));
    end
    chk("rr_out1", {16'h0, out1}, 32'h00000009);
    chk("rr_out8", {16'h0, out8}, 32'h00000008);
    drive(1'b0, 16'h0000, 1'b1, 3'd0, 8'hFF);
    cycle("rr_drain");

    // back-pressure on channel 2
    drive(1'b1, 16'h1111, 1'b0, 3'd2, 8'h00);
    cycle("bp_first");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h2222, 1'b0, 3'd2, 8'h00);
      cycle($sformatf("bp_stall_%0d", i));
      chk($sformatf("bp_hold_%0d", i), {16'h0, out3}, 32'h00001111);
    end
    drive(1'b1, 16'h2222, 1'b0, 3'd2, 8'h04);
    #1;
    chk("bp_ready_on_ack", {31'h0, in_ready}, 32'h1);
    cycle("bp_refill");
    chk("bp_out3", {16'h0, out3}, 32'h00002222);
    chk("bp_valid2", {31'h0, out_valid[2]}, 32'h1);

    // ack on empty channels is ignored
    do_reset();
    drive(1'b0, 16'h0000, 1'b0, 3'd0, 8'hFF);
    cycle("ack_empty");

    // full stall in auto mode: fill all eight, pointer wraps onto full channel 0
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h3000 + 16'(i), 1'b1, 3'd0, 8'h00);
      cycle($sformatf("fill_%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h4444, 1'b1, 3'd0, 8'h00);
      cycle($sformatf("full_stall_%0d", i));
      chk($sformatf("full_ptr_%0d", i), {29'h0, ptr}, 32'h0);
    end
    drive(1'b1, 16'h4444, 1'b1, 3'd0, 8'h01);
    cycle("full_release");
    chk("full_ptr_adv", {29'h0, ptr}, 32'h1);

    // mid-run async reset with out_valid=FF and ptr=5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h5000 + 16'(i), 1'b1, 3'd0, 8'h00);
      cycle($sformatf("pre_auto_%0d", i));
    end
    for (int i = 5; i < 8; i++) begin
      drive(1'b1, 16'h5000 + 16'(i), 1'b0, 3'(i), 8'h00);
      cycle($sformatf("pre_sel_%0d", i));
    end
    chk("pre_valid_ff", {24'h0, out_valid}, 32'h000000FF);
    chk("pre_ptr5", {29'h0, ptr}, 32'h5);
    drive(1'b0, 16'h0000, 1'b1, 3'd0, 8'h00);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_state("async_rst");
    #2;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'h0, in_ready}, 32'h1);
    drive(1'b1, 16'h6666, 1'b1, 3'd0, 8'h00);
    cycle("post_rst_first");
    chk("post_rst_out1", {16'h0, out1}, 32'h00006666);

    // mode switch at ptr=4
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h7000 + 16'(i), 1'b1, 3'd0, 8'hFF);
      cycle($sformatf("ms_pre_%0d", i));
    end
    drive(1'b1, 16'hBEEF, 1'b0, 3'd6, 8'h00);
    cycle("ms_explicit");
    chk("ms_out7", {16'h0, out7}, 32'h0000BEEF);
    chk("ms_ptr4", {29'h0, ptr}, 32'h4);
    drive(1'b1, 16'hCAFE, 1'b1, 3'd6, 8'h00);
    cycle("ms_auto");
    chk("ms_out5", {16'h0, out5}, 32'h0000CAFE);
    chk("ms_ptr5", {29'h0, ptr}, 32'h5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 8'($urandom & $urandom));
      cycle($sformatf("rnd_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
